// File: rtl/layer_act_sequencer.sv
// rtl/layer_act_sequencer.sv - deserialise activations to a layer, capture node outputs, serialise them downstream
module layer_act_sequencer #(
  parameter int N_IN     = 10,
  parameter int N_OUT    = 16,
  parameter int DW       = 8,
  parameter int NODE_LAT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DW-1:0]         s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [N_IN*DW-1:0]    a_bus,
  input  logic [N_OUT*DW-1:0]   n_bus,
  output logic [DW-1:0]         m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  // wait_cnt must be able to hold NODE_LAT itself
  localparam int WW = $clog2(NODE_LAT + 1);

  localparam logic [IW-1:0] IN_LAST   = IW'(N_IN - 1);
  localparam logic [OW-1:0] OUT_LAST  = OW'(N_OUT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(NODE_LAT);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        in_cnt_q, in_cnt_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [OW-1:0]        out_cnt_q, out_cnt_d;
  logic [OW-1:0]        out_nxt;
  logic [N_IN*DW-1:0]   a_bus_q, a_bus_d;
  logic [N_OUT*DW-1:0]  buf_q, buf_d;
  logic [DW-1:0]        m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 s_ready_q, s_ready_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  assign out_nxt    = out_cnt_q + 1'b1;
  assign s_ready    = s_ready_q;
  assign a_bus      = a_bus_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // Next-state and registered-output computation for the LOAD/WAIT/SEND cycle
  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    out_cnt_d    = out_cnt_q;
    a_bus_d      = a_bus_q;
    buf_d        = buf_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    s_ready_d    = s_ready_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_LOAD: begin
        s_ready_d = 1'b1;
        if (s_valid && s_ready_q) begin
          a_bus_d[in_cnt_q*DW +: DW] = s_data;
          if (in_cnt_q == IN_LAST) begin
            in_cnt_d   = '0;
            s_ready_d  = 1'b0;
            wait_cnt_d = '0;
            state_d    = S_WAIT;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        // a_bus stays frozen; node pipeline output is valid once NODE_LAT edges have passed
        if (wait_cnt_q == WAIT_LAST) begin
          buf_d     = n_bus;
          out_cnt_d = '0;
          m_data_d  = n_bus[DW-1:0];
          m_valid_d = 1'b1;
          state_d   = S_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        if (m_valid_q && m_ready) begin
          if (out_cnt_q == OUT_LAST) begin
            out_cnt_d    = '0;
            m_valid_d    = 1'b0;
            frame_done_d = 1'b1;
            s_ready_d    = 1'b1;
            state_d      = S_LOAD;
          end else begin
            out_cnt_d = out_nxt;
            m_data_d  = buf_q[out_nxt*DW +: DW];
          end
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    busy_d = (state_d != S_LOAD);
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      in_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      out_cnt_q    <= '0;
      a_bus_q      <= '0;
      buf_q        <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      s_ready_q    <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      out_cnt_q    <= out_cnt_d;
      a_bus_q      <= a_bus_d;
      buf_q        <= buf_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_layer_act_sequencer.sv
// tb/tb_layer_act_sequencer.sv - self-checking bench for layer_act_sequencer
module tb_layer_act_sequencer;

  localparam int N_IN     = 10;
  localparam int N_OUT    = 16;
  localparam int DW       = 8;
  localparam int NODE_LAT = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DW-1:0]        s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [N_IN*DW-1:0]   a_bus;
  logic [N_OUT*DW-1:0]  n_bus;
  logic [DW-1:0]        m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 busy;
  logic                 frame_done;

  int checks = 0;
  int errors = 0;
  int node_mode = 0;

  logic [N_IN*DW-1:0] p1, p2, p3;
  logic [DW-1:0] model_a [N_IN];
  logic [DW-1:0] fr [N_IN];

  layer_act_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .NODE_LAT(NODE_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .a_bus(a_bus), .n_bus(n_bus),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Node output as a function of a whole input vector; mode 1 makes every output depend on the last slot
  function automatic logic [DW-1:0] node_fn(input logic [N_IN*DW-1:0] v, input int j, input int mode);
    logic [DW-1:0] x;
    if (mode == 0) x = DW'(j + 32);
    else x = v[(j % N_IN)*DW +: DW] + v[(N_IN-1)*DW +: DW] + DW'(j * 3);
    return x;
  endfunction

  // Three-register node pipeline (input, sum, ReLU)
  always @(posedge clk) begin
    p1 <= a_bus;
    p2 <= p1;
    p3 <= p2;
  end

  // Node outputs presented on n_bus
  always_comb begin
    n_bus = '0;
    for (int j = 0; j < N_OUT; j++) n_bus[j*DW +: DW] = node_fn(p3, j, node_mode);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [N_IN*DW-1:0] pack_model();
    logic [N_IN*DW-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i*DW +: DW] = model_a[i];
    return v;
  endfunction

  task automatic run_frame(input int rmode, input bit flood, input bit gaps, input int abort_at);
    int idx, guard, lat, outi, k;
    logic [N_IN*DW-1:0] exp_vec;
    logic [DW-1:0] exp_out [N_OUT];
    idx = 0;
    guard = 0;
    while (idx < N_IN && guard < 400) begin
      check("s_ready_load", s_ready, 1);
      check("busy_load", busy, 0);
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data = fr[idx];
      if (s_valid && s_ready) begin
        model_a[idx] = fr[idx];
        idx++;
      end
      tick();
      guard++;
    end
    if (idx < N_IN) check("load_timeout", idx, N_IN);
    s_valid = flood;
    s_data = 8'h7F;
    exp_vec = pack_model();
    for (int j = 0; j < N_OUT; j++) exp_out[j] = node_fn(exp_vec, j, node_mode);
    check("s_ready_e0", s_ready, 0);
    check("busy_e0", busy, 1);
    check("a_bus_e0", a_bus, exp_vec);
    lat = 0;
    while (!m_valid && lat < 50) begin
      check("a_bus_wait", a_bus, exp_vec);
      check("s_ready_wait", s_ready, 0);
      check("busy_wait", busy, 1);
      tick();
      lat++;
    end
    check("capture_lat", lat, NODE_LAT + 1);
    outi = 0;
    k = 0;
    while (outi < N_OUT && k < 400) begin
      check("m_valid_send", m_valid, 1);
      check("m_data_send", m_data, exp_out[outi]);
      check("frame_done_send", frame_done, 0);
      check("a_bus_send", a_bus, exp_vec);
      check("s_ready_send", s_ready, 0);
      if (abort_at >= 0 && outi == abort_at) begin
        reset = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick();
        reset = 1'b0;
        check("abort_m_valid", m_valid, 0);
        check("abort_a_bus", a_bus, 0);
        check("abort_s_ready", s_ready, 1);
        check("abort_frame_done", frame_done, 0);
        check("abort_busy", busy, 0);
        check("abort_m_data", m_data, 0);
        for (int i = 0; i < N_IN; i++) model_a[i] = '0;
        tick();
        check("abort_frame_done2", frame_done, 0);
        return;
      end
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = ((k % 3) == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (m_ready) outi++;
      tick();
      k++;
    end
    if (outi < N_OUT) check("send_timeout", outi, N_OUT);
    check("frame_done_pulse", frame_done, 1);
    check("m_valid_end", m_valid, 0);
    check("s_ready_end", s_ready, 1);
    check("busy_end", busy, 0);
    check("a_bus_end", a_bus, exp_vec);
    s_valid = 1'b0;
    m_ready = 1'b0;
    tick();
    check("frame_done_once", frame_done, 0);
  endtask

  initial begin
    reset = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    for (int i = 0; i < N_IN; i++) model_a[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_a_bus", a_bus, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_data", m_data, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);

    // Bytes 1..10, constant node outputs j+0x20
    node_mode = 0;
    for (int i = 0; i < N_IN; i++) fr[i] = DW'(i + 1);
    run_frame(0, 1'b0, 1'b0, -1);
    check("a_bus_seq", a_bus, 80'h0A090807060504030201);

    // Function-of-input nodes, m_ready pattern 1,0,0
    node_mode = 1;
    for (int i = 0; i < N_IN; i++) fr[i] = DW'($urandom);
    run_frame(1, 1'b0, 1'b0, -1);

    // Upstream flooding 0x7F during WAIT/SEND, random m_ready
    for (int i = 0; i < N_IN; i++) fr[i] = DW'($urandom);
    run_frame(2, 1'b1, 1'b0, -1);

    // Abort on the third output byte
    for (int i = 0; i < N_IN; i++) fr[i] = DW'($urandom);
    run_frame(0, 1'b0, 1'b0, 2);

    // Fresh frame after the abort
    for (int i = 0; i < N_IN; i++) fr[i] = 8'h80;
    run_frame(0, 1'b0, 1'b0, -1);

    // Two consecutive frames with distinct data
    for (int i = 0; i < N_IN; i++) fr[i] = DW'(i + 1);
    run_frame(0, 1'b1, 1'b0, -1);
    for (int i = 0; i < N_IN; i++) fr[i] = DW'(8'hF0 + i);
    run_frame(1, 1'b1, 1'b0, -1);

    // Random frames with upstream gaps and random stalls
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N_IN; i++) fr[i] = DW'($urandom);
      run_frame(2, 1'($urandom_range(0, 1)), 1'b1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
